bldc_commutator: RTL and testbench
==================================

Name: bldc_commutator

Overview:
- Six-step commutation sequencer for the three-phase BLDC gate driver (INHA/INLA/INHB/INLB/INHC/INLC), clocked at 32 MHz.
- Takes the raw hall inputs (already pulled up in the IO cell), the PWM output of the pwm block and the direction from the duty sign logic.
- Produces the gate enables with break-before-make dead time, plus fault detection and commutation speed/position telemetry for coms.

Parameters:
- FILTER_CYCLES, 16, consecutive stable cycles required before a synchronised hall code is accepted (1..255).
- DEAD_CYCLES, 32, all-off cycles inserted on every commutation pattern change (1..1023).
- STALL_CYCLES, 3_200_000, maximum cycles in DRIVE without an accepted sector change; 0 disables the stall check.
- PERIOD_W, 24, width of the period counter.

Ports:
- clk  in  1  32 MHz clock
- reset_n  in  1  asynchronous active-low reset
- hall  in  3  raw hall sensors {h3,h2,h1}, asynchronous
- pwm_in  in  1  PWM from the pwm block, gated onto the active high side
- dir  in  1  0 = forward, 1 = reverse
- enable  in  1  drive request; low clears fault
- inh  out  3  high-side enables {C,B,A}
- inl  out  3  low-side enables {C,B,A}
- sector  out  3  current accepted sector 0..5; 7 = invalid
- fault  out  2  0 none, 1 invalid hall, 2 stall, 3 illegal jump
- comm_period  out  PERIOD_W  cycles between the last two accepted sector changes, saturating
- comm_count  out  24  signed step counter: +1 per forward step, -1 per reverse step, wraps

Behaviour:
- Reset values: inh=0, inl=0, sector=7, fault=0, comm_period=all ones, comm_count=0, state=IDLE, filter counter=0.

Hall input path:
- hall passes through a 2-FF synchroniser into a candidate register.
- The filter counter clears whenever the synchronised value differs from the candidate.
- When the candidate has been stable for FILTER_CYCLES cycles, it is accepted.
- Total latency from the sync input to the accepted code is 2+FILTER_CYCLES clocks.

Sector decode (accepted code, h3h2h1):
- 101=0, 100=1, 110=2, 010=3, 011=4, 001=5.
- 000 and 111 decode to 7 (invalid).

Forward drive pattern (high/low phase):
- s0 A/B, s1 A/C, s2 B/C, s3 B/A, s4 C/A, s5 C/B.
- Reverse (dir=1) swaps the high and low phase of the same sector.
- In DRIVE: inh[high]=pwm_in (combinational gate of a registered select), inl[low]=1, all other bits 0.
- inh and inl are never both 1 on the same phase.

State machine:
- IDLE: outputs 0. enable=1 -> DEAD.
- DEAD: outputs 0; counter loads DEAD_CYCLES-1 and decrements. At 0: sector valid -> DRIVE; otherwise -> FAULT with code 1.
- DRIVE:
  - Change in the accepted sector or in dir -> DEAD. Pattern and sector latch on the DEAD->DRIVE transition.
  - sector==7 -> FAULT (1).
  - Sector change that is not ±1 mod 6 -> FAULT (3).
  - Stall timer reaching STALL_CYCLES -> FAULT (2).
  - enable=0 -> IDLE.
  - Priority: enable=0 > invalid > jump > stall > sector/dir change.
- FAULT: outputs 0 and fault held sticky; enable=0 -> IDLE with fault cleared.

Timers:
- The stall timer clears on entering DRIVE and on each accepted sector change, and counts only in DRIVE.

Telemetry (comm_count and comm_period):
- comm_count and comm_period update on every accepted valid ±1 sector change in any state, so a coasting motor is still measured.
- comm_count: +1 if new sector = old+1 mod 6, -1 if old-1 mod 6.
- comm_period: the period counter is captured, then restarts at 1. The counter saturates at 2^PERIOD_W-1.

Boundary cases:
- Sector change and dir change in the same cycle: a single DEAD interval.
- Sector change during DEAD: the counter reloads, extending the dead time.
- reset_n low at any time: all outputs go immediately to their reset values (asynchronous).

Test Plan:
- reset_n=0 then release, enable=0, hall=101 -> after 18 clocks sector=0, inh=inl=0, fault=0.
- enable=1, hall=101, dir=0, pwm_in toggling -> 32 all-off clocks, then inh=001 following pwm_in, inl=010.
- hall steps 101->100 with drive active -> 2+16 clocks later all outputs 0 for 32 clocks, then inh=001, inl=100. comm_count=+1, comm_period equals the measured gap.
- 3-cycle glitch 101->000->101 -> no sector change, no fault. A sustained 000 -> fault=1, outputs 0, cleared only by enable=0.
- Jump 101->110 (0->2) while in DRIVE -> fault=3. With STALL_CYCLES=1000 and hall held constant -> fault=2 exactly 1000 DRIVE cycles after entry.
- dir toggled in s0 -> dead time, then inh=010, inl=001. reset_n asserted mid-DEAD -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/bldc_commutator_if.sv
// Signal bundle between the commutator and its neighbours:
// hall/PWM/direction/enable in, gate enables and telemetry out.
interface bldc_commutator_if #(
   parameter int PERIOD_W = 24
);
   logic [2:0]          hall;
   logic                pwm_in;
   logic                dir;
   logic                enable;
   logic [2:0]          inh;
   logic [2:0]          inl;
   logic [2:0]          sector;
   logic [1:0]          fault;
   logic [PERIOD_W-1:0] comm_period;
   logic [23:0]         comm_count;

   modport master (
      output hall, pwm_in, dir, enable,
      input  inh, inl, sector, fault, comm_period, comm_count
   );

   modport slave (
      input  hall, pwm_in, dir, enable,
      output inh, inl, sector, fault, comm_period, comm_count
   );
endinterface

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation sequencer: hall synchroniser and glitch filter,
// sector decode, dead-time FSM with fault detection, step telemetry.
module bldc_commutator #(
   parameter int FILTER_CYCLES = 16,
   parameter int DEAD_CYCLES   = 32,
   parameter int STALL_CYCLES  = 3_200_000,
   parameter int PERIOD_W      = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   bldc_commutator_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DEAD, DRIVE, FAULT} state_t;

   localparam logic [2:0]          SEC_INVALID = 3'd7;
   localparam logic [7:0]          FILT_MAX    = 8'(FILTER_CYCLES);
   localparam logic [9:0]          DEAD_LOAD   = 10'(DEAD_CYCLES - 1);
   localparam logic [31:0]         STALL_LIM   = 32'(STALL_CYCLES);
   localparam logic [PERIOD_W-1:0] PERIOD_MAX  = '1;

   // Hall code to sector number; the two all-equal codes are impossible on a healthy motor.
   function automatic logic [2:0] decode_hall(input logic [2:0] code);
      logic [2:0] s;
      case (code)
         3'b101:  s = 3'd0;
         3'b100:  s = 3'd1;
         3'b110:  s = 3'd2;
         3'b010:  s = 3'd3;
         3'b011:  s = 3'd4;
         3'b001:  s = 3'd5;
         default: s = SEC_INVALID;
      endcase
      return s;
   endfunction

   function automatic logic [2:0] sec_plus(input logic [2:0] s);
      return (s == 3'd5) ? 3'd0 : s + 3'd1;
   endfunction

   function automatic logic [2:0] sec_minus(input logic [2:0] s);
      return (s == 3'd0) ? 3'd5 : s - 3'd1;
   endfunction

   // {high-side one-hot, low-side one-hot}; reverse swaps the two phases.
   function automatic logic [5:0] drive_pattern(input logic [2:0] s, input logic rev);
      logic [2:0] hi;
      logic [2:0] lo;
      hi = 3'b000;
      lo = 3'b000;
      case (s)
         3'd0: begin hi = 3'b001; lo = 3'b010; end
         3'd1: begin hi = 3'b001; lo = 3'b100; end
         3'd2: begin hi = 3'b010; lo = 3'b100; end
         3'd3: begin hi = 3'b010; lo = 3'b001; end
         3'd4: begin hi = 3'b100; lo = 3'b001; end
         3'd5: begin hi = 3'b100; lo = 3'b010; end
         default: begin hi = 3'b000; lo = 3'b000; end
      endcase
      return rev ? {lo, hi} : {hi, lo};
   endfunction

   logic [2:0]          hall_meta_reg, hall_sync_reg, cand_reg;
   logic [7:0]          filt_cnt_reg, filt_cnt_next;
   logic [2:0]          sector_reg;
   logic [2:0]          dec_sector;
   logic                acc_load, sec_chg, step_fwd, step_rev, sec_jump;
   state_t              state_reg;
   logic [9:0]          dead_cnt_reg;
   logic [31:0]         stall_cnt_reg;
   logic [2:0]          hi_sel_reg, inl_reg;
   logic [1:0]          fault_reg;
   logic                drive_dir_reg;
   logic [PERIOD_W-1:0] period_cnt_reg, comm_period_reg;
   logic [23:0]         comm_count_reg;

   // Stability count: a fresh mismatch counts as the first stable cycle, so the
   // code is accepted FILTER_CYCLES clocks after it reaches the sync stage.
   always_comb begin
      filt_cnt_next = filt_cnt_reg;
      if (hall_sync_reg != cand_reg) begin
         filt_cnt_next = 8'd1;
      end else if (filt_cnt_reg != FILT_MAX) begin
         filt_cnt_next = filt_cnt_reg + 8'd1;
      end
   end

   assign acc_load   = (filt_cnt_next == FILT_MAX);
   assign dec_sector = decode_hall(hall_sync_reg);
   assign sec_chg    = acc_load && (dec_sector != sector_reg);
   assign step_fwd   = sec_chg && (sector_reg != SEC_INVALID) && (dec_sector == sec_plus(sector_reg));
   assign step_rev   = sec_chg && (sector_reg != SEC_INVALID) && (dec_sector == sec_minus(sector_reg));
   assign sec_jump   = sec_chg && (dec_sector != SEC_INVALID) && !step_fwd && !step_rev;

   // Synchronise hall, track the candidate and publish the accepted sector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hall_meta_reg <= 3'b000;
         hall_sync_reg <= 3'b000;
         cand_reg      <= 3'b000;
         filt_cnt_reg  <= 8'd0;
         sector_reg    <= SEC_INVALID;
      end else begin
         hall_meta_reg <= bus.hall;
         hall_sync_reg <= hall_meta_reg;
         cand_reg      <= hall_sync_reg;
         filt_cnt_reg  <= filt_cnt_next;
         if (acc_load) begin
            sector_reg <= dec_sector;
         end
      end
   end

   // Step counter and period capture run in every state so coasting is measured.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_cnt_reg  <= '0;
         comm_period_reg <= '1;
         comm_count_reg  <= 24'd0;
      end else if (step_fwd || step_rev) begin
         comm_period_reg <= period_cnt_reg;
         period_cnt_reg  <= PERIOD_W'(1);
         comm_count_reg  <= step_fwd ? comm_count_reg + 24'd1 : comm_count_reg - 24'd1;
      end else if (period_cnt_reg != PERIOD_MAX) begin
         period_cnt_reg <= period_cnt_reg + PERIOD_W'(1);
      end
   end

   // Commutation FSM with registered gate selects and sticky fault code.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         dead_cnt_reg  <= 10'd0;
         stall_cnt_reg <= 32'd0;
         hi_sel_reg    <= 3'b000;
         inl_reg       <= 3'b000;
         fault_reg     <= 2'd0;
         drive_dir_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               hi_sel_reg <= 3'b000;
               inl_reg    <= 3'b000;
               fault_reg  <= 2'd0;
               if (bus.enable) begin
                  state_reg    <= DEAD;
                  dead_cnt_reg <= DEAD_LOAD;
               end
            end
            DEAD: begin
               hi_sel_reg <= 3'b000;
               inl_reg    <= 3'b000;
               if (!bus.enable) begin
                  state_reg <= IDLE;
               end else if (sec_chg) begin
                  dead_cnt_reg <= DEAD_LOAD;
               end else if (dead_cnt_reg != 10'd0) begin
                  dead_cnt_reg <= dead_cnt_reg - 10'd1;
               end else if (sector_reg != SEC_INVALID) begin
                  state_reg               <= DRIVE;
                  {hi_sel_reg, inl_reg}   <= drive_pattern(sector_reg, bus.dir);
                  drive_dir_reg           <= bus.dir;
                  stall_cnt_reg           <= 32'd0;
               end else begin
                  state_reg <= FAULT;
                  fault_reg <= 2'd1;
               end
            end
            DRIVE: begin
               if (!bus.enable || sec_chg || (bus.dir != drive_dir_reg) ||
                   ((STALL_LIM != 32'd0) && (stall_cnt_reg == STALL_LIM - 32'd1))) begin
                  hi_sel_reg <= 3'b000;
                  inl_reg    <= 3'b000;
               end
               if (!bus.enable) begin
                  state_reg <= IDLE;
               end else if (sec_chg && (dec_sector == SEC_INVALID)) begin
                  state_reg <= FAULT;
                  fault_reg <= 2'd1;
               end else if (sec_jump) begin
                  state_reg <= FAULT;
                  fault_reg <= 2'd3;
               end else if ((STALL_LIM != 32'd0) && (stall_cnt_reg == STALL_LIM - 32'd1)) begin
                  state_reg <= FAULT;
                  fault_reg <= 2'd2;
               end else if (sec_chg || (bus.dir != drive_dir_reg)) begin
                  state_reg    <= DEAD;
                  dead_cnt_reg <= DEAD_LOAD;
               end else begin
                  stall_cnt_reg <= stall_cnt_reg + 32'd1;
               end
            end
            FAULT: begin
               hi_sel_reg <= 3'b000;
               inl_reg    <= 3'b000;
               if (!bus.enable) begin
                  state_reg <= IDLE;
                  fault_reg <= 2'd0;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // High side chops with the PWM; the low side stays solidly on.
   assign bus.inh         = hi_sel_reg & {3{bus.pwm_in}};
   assign bus.inl         = inl_reg;
   assign bus.sector      = sector_reg;
   assign bus.fault       = fault_reg;
   assign bus.comm_period = comm_period_reg;
   assign bus.comm_count  = comm_count_reg;
endmodule

// File: tb/tb_bldc_commutator.sv
// Randomised bench for bldc_commutator against a table-driven motor model.
`timescale 1ns/1ps
module tb_bldc_commutator;
   localparam int FILTER = 16;
   localparam int DEAD   = 32;
   localparam int STALL  = 1000;
   localparam int PW     = 24;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   bldc_commutator_if #(.PERIOD_W(PW)) bus ();

   bldc_commutator #(
      .FILTER_CYCLES(FILTER),
      .DEAD_CYCLES(DEAD),
      .STALL_CYCLES(STALL),
      .PERIOD_W(PW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Random PWM, changed mid-cycle so samples at edge+1 see a settled value.
   initial begin
      bus.pwm_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.pwm_in = 1'($urandom_range(0, 1));
      end
   end

   // Motor model: sector tables and running telemetry.
   int sec_of  [8] = '{7, 5, 3, 4, 1, 0, 2, 7};
   int hall_of [6] = '{5, 4, 6, 2, 3, 1};
   int hi_ph   [6] = '{0, 0, 1, 1, 2, 2};
   int lo_ph   [6] = '{1, 2, 2, 0, 0, 1};
   int m_sector = 7;
   int m_count  = 0;
   int m_steps  = 0;
   int m_last_acc = 0;
   int m_period = 0;
   bit m_dir = 1'b0;

   task automatic check_value(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_off(input string tag);
      check_value({tag, "_inh"}, bus.inh, 0);
      check_value({tag, "_inl"}, bus.inl, 0);
   endtask

   task automatic expect_drive(input string tag);
      int h;
      int l;
      h = m_dir ? lo_ph[m_sector] : hi_ph[m_sector];
      l = m_dir ? hi_ph[m_sector] : lo_ph[m_sector];
      check_value({tag, "_inh"}, bus.inh, bus.pwm_in ? (1 << h) : 0);
      check_value({tag, "_inl"}, bus.inl, 1 << l);
   endtask

   // One +/-1 hall step; optional dir flip landing on the same accept edge.
   task automatic do_step(input bit fwd, input bit with_dir, input bit driving);
      int ns;
      int acc;
      ns  = fwd ? (m_sector + 1) % 6 : (m_sector + 5) % 6;
      bus.hall = 3'(hall_of[ns]);
      acc = cyc + 2 + FILTER;
      tick(1 + FILTER);
      check_value("step_hold_sector", bus.sector, m_sector);
      if (driving) expect_drive("step_hold");
      else expect_off("step_hold");
      if (with_dir) begin
         bus.dir = ~bus.dir;
         m_dir   = ~m_dir;
      end
      tick(1);
      m_count += fwd ? 1 : -1;
      if (m_steps > 0) m_period = acc - m_last_acc;
      m_last_acc = acc;
      m_steps++;
      m_sector = ns;
      check_value("step_sector", bus.sector, m_sector);
      check_value("step_count", bus.comm_count, m_count & 'hFFFFFF);
      if (m_steps > 1) check_value("step_period", bus.comm_period, m_period);
      expect_off("step_dead_first");
      if (driving) begin
         tick(DEAD - 1);
         expect_off("step_dead_last");
         tick(1);
         expect_drive("step_drive");
      end
      $display("step fwd=%0d dir_flip=%0d sector=%0d count=%0d period=%0d",
               fwd, with_dir, m_sector, m_count, m_period);
   endtask

   task automatic do_dir_flip();
      bus.dir = ~bus.dir;
      m_dir   = ~m_dir;
      tick(1);
      expect_off("dir_dead_first");
      tick(DEAD - 1);
      expect_off("dir_dead_last");
      tick(1);
      expect_drive("dir_drive");
      $display("dir flip dir=%0d sector=%0d", m_dir, m_sector);
   endtask

   initial begin
      int p;
      int ns;
      bus.hall   = 3'b101;
      bus.dir    = 1'b0;
      bus.enable = 1'b0;

      // Reset values, then filter latency from release.
      tick(3);
      check_value("rst_sector", bus.sector, 7);
      check_value("rst_fault", bus.fault, 0);
      check_value("rst_count", bus.comm_count, 0);
      check_value("rst_period", bus.comm_period, 'hFFFFFF);
      expect_off("rst");
      reset_n = 1'b1;
      tick(1 + FILTER);
      check_value("filt_early_sector", bus.sector, 7);
      tick(1);
      m_sector = sec_of[5];
      check_value("filt_accept_sector", bus.sector, m_sector);
      check_value("filt_accept_fault", bus.fault, 0);
      expect_off("filt_accept");
      $display("reset released, sector=%0d", m_sector);

      // Enable: dead time, then drive sector 0.
      bus.enable = 1'b1;
      tick(DEAD);
      expect_off("en_dead_last");
      tick(1);
      expect_drive("en_drive");
      check_value("en_period_idle", bus.comm_period, 'hFFFFFF);
      $display("enable, driving sector=%0d", m_sector);

      // Randomised commutation run; first transaction is a forward step.
      for (int i = 0; i < 16; i++) begin
         if (i != 0 && $urandom_range(0, 3) == 0) do_dir_flip();
         else do_step(i == 0 ? 1'b1 : 1'($urandom_range(0, 1)),
                      i != 0 && $urandom_range(0, 4) == 0, 1'b1);
         tick($urandom_range(1, 150));
         expect_drive("dwell");
      end

      // Short invalid glitch must be filtered out.
      bus.hall = 3'b000;
      tick(3);
      bus.hall = 3'(hall_of[m_sector]);
      tick(30);
      check_value("glitch_sector", bus.sector, m_sector);
      check_value("glitch_fault", bus.fault, 0);
      expect_drive("glitch");
      $display("glitch filtered, sector=%0d", m_sector);

      // Sustained invalid code: sticky fault 1 until enable drops.
      p = m_sector;
      bus.hall = 3'b000;
      tick(1 + FILTER);
      check_value("inv_pre_fault", bus.fault, 0);
      tick(1);
      m_sector = 7;
      check_value("inv_fault", bus.fault, 1);
      check_value("inv_sector", bus.sector, 7);
      expect_off("inv");
      bus.hall = 3'(hall_of[p]);
      tick(FILTER + 8);
      m_sector = p;
      check_value("inv_sticky_fault", bus.fault, 1);
      check_value("inv_recover_sector", bus.sector, m_sector);
      check_value("inv_count_kept", bus.comm_count, m_count & 'hFFFFFF);
      bus.enable = 1'b0;
      tick(1);
      check_value("inv_clear_fault", bus.fault, 0);
      $display("invalid hall fault raised and cleared");

      // Coasting: telemetry still updates while idle.
      do_step(1'($urandom_range(0, 1)), 1'b0, 1'b0);

      // Illegal jump of two sectors while driving.
      bus.enable = 1'b1;
      tick(DEAD + 1);
      expect_drive("jump_pre");
      ns = (m_sector + 2) % 6;
      bus.hall = 3'(hall_of[ns]);
      tick(1 + FILTER);
      check_value("jump_pre_fault", bus.fault, 0);
      tick(1);
      m_sector = ns;
      check_value("jump_fault", bus.fault, 3);
      check_value("jump_count_kept", bus.comm_count, m_count & 'hFFFFFF);
      expect_off("jump");
      bus.enable = 1'b0;
      tick(1);
      check_value("jump_clear_fault", bus.fault, 0);
      $display("jump fault raised and cleared");

      // Stall: fault 2 exactly STALL cycles after entering DRIVE.
      bus.enable = 1'b1;
      tick(DEAD + 1);
      expect_drive("stall_entry");
      tick(STALL - 1);
      check_value("stall_pre_fault", bus.fault, 0);
      expect_drive("stall_pre");
      tick(1);
      check_value("stall_fault", bus.fault, 2);
      expect_off("stall");
      bus.enable = 1'b0;
      tick(1);
      check_value("stall_clear_fault", bus.fault, 0);
      $display("stall fault raised and cleared");

      // Asynchronous reset in the middle of DEAD.
      bus.enable = 1'b1;
      tick(10);
      check_value("arst_pre_sector", bus.sector, m_sector);
      #2;
      reset_n = 1'b0;
      #1;
      check_value("arst_sector", bus.sector, 7);
      check_value("arst_fault", bus.fault, 0);
      check_value("arst_count", bus.comm_count, 0);
      check_value("arst_period", bus.comm_period, 'hFFFFFF);
      expect_off("arst");
      $display("async reset mid-dead");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
